// File: rtl/exu_wb_queue.sv
// rtl/exu_wb_queue.sv - in-order result staging FIFO between one EXU and the CDB arbiter
module exu_wb_queue #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32,
   parameter int ID_W   = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [TAG_W-1:0]           in_tag,
   input  logic [DATA_W-1:0]          in_wdata,
   input  logic [ID_W-1:0]            in_inst_id,
   output logic                       out_req,
   input  logic                       out_rdy,
   output logic [TAG_W-1:0]           out_tag,
   output logic [DATA_W-1:0]          out_wdata,
   output logic [ID_W-1:0]            out_inst_id,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [TAG_W-1:0]  mem_tag  [DEPTH];
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [ID_W-1:0]   mem_id   [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [AW-1:0] head_idx;
   logic          push;
   logic          pop;

   // Handshake qualification; no pop-to-push bypass when full
   always_comb begin
      full     = (count_q == CW'(DEPTH));
      in_ready = ~full & ~rst;
      out_req  = (count_q != '0);
      push     = in_valid & in_ready;
      pop      = out_req & out_rdy;
      count    = count_q;
   end

   // Head read: when empty, rd_ptr-1 is the slot popped last, so outputs hold its content
   always_comb begin
      head_idx    = out_req ? rd_ptr : rd_ptr - AW'(1);
      out_tag     = mem_tag[head_idx];
      out_wdata   = mem_data[head_idx];
      out_inst_id = mem_id[head_idx];
   end

   // Pointer, occupancy and storage update; rst beats flush beats push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_tag[i]  <= '0;
            mem_data[i] <= '0;
            mem_id[i]   <= '0;
         end
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem_tag[wr_ptr]  <= in_tag;
            mem_data[wr_ptr] <= in_wdata;
            mem_id[wr_ptr]   <= in_inst_id;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // Occupancy must stay within 0..DEPTH
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && full)) else $error("push while full");
         assert (!(pop && count_q == '0)) else $error("pop while empty");
      end
   end

endmodule
